// File: rtl/serial_adder_n.sv
// Digit-serial adder: adds a + b + cin, DIGIT bits per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERADD_OVF_EN.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_adder_n: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] dig_w;
    logic [WIDTH-1:0] res_next;

    // Operands shift right each cycle, so the current digit is always at the bottom.
    always_comb begin
        dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        dig_w = '0;
        dig_w[WIDTH-DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        res_next = (res >> DIGIT) | dig_w;
    end

`ifdef SERADD_OVF_EN
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
    logic msb_cin;
    assign msb_cin = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
`endif

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= dsum[DIGIT];
                    res   <= res_next;
                    if (cnt == CW'(N - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= dsum[DIGIT];
`ifdef SERADD_OVF_EN
                        ovf   <= msb_cin ^ dsum[DIGIT];
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n with DIGIT = 1, 4 and 8 instances (WIDTH = 8).
// Overflow checks are compiled in when SERADD_OVF_EN is defined.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;

    logic       busy1, done1, cout1, busy4, done4, cout4, busy8, done8, cout8;
    logic [7:0] sum1, sum4, sum8;
`ifdef SERADD_OVF_EN
    logic       ovf1, ovf4, ovf8;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERADD_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            1:       return done1;
            4:       return done4;
            default: return done8;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1:       return busy1;
            4:       return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [7:0] get_sum(input int sel);
        case (sel)
            1:       return sum1;
            4:       return sum4;
            default: return sum8;
        endcase
    endfunction

    function automatic logic get_cout(input int sel);
        case (sel)
            1:       return cout1;
            4:       return cout4;
            default: return cout8;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            1:       start1 = v;
            4:       start4 = v;
            default: start8 = v;
        endcase
    endtask

    // Accepts one operation and waits (bounded) for done; leaves time inside the done cycle.
    task automatic op(input int sel, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input int exp_lat, input logic [7:0] es, input logic ec, input string tag);
        int lat;
        int busy_cnt;
        a = va; b = vb; cin = vc;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        lat = 0;
        busy_cnt = 0;
        while (!get_done(sel) && lat < 50) begin
            if (get_busy(sel)) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_busy_at_done"}, {31'b0, get_busy(sel)}, 0);
        chk({tag, "_sum"}, {24'b0, get_sum(sel)}, {24'b0, es});
        chk({tag, "_cout"}, {31'b0, get_cout(sel)}, {31'b0, ec});
    endtask

    initial begin
        int lat;
        int extra;

        tick();
        tick();
        chk("reset_busy", {31'b0, busy1}, 0);
        chk("reset_done", {31'b0, done1}, 0);
        chk("reset_sum", {24'b0, sum1}, 0);
        chk("reset_cout", {31'b0, cout1}, 0);
`ifdef SERADD_OVF_EN
        chk("reset_ovf", {31'b0, ovf1}, 0);
`endif
        rst_n = 1'b1;
        tick();

        // T1: zero operands, check done is a single-cycle pulse
        op(1, 8'h00, 8'h00, 1'b0, 8, 8'h00, 1'b0, "t1");
        tick();
        chk("t1_done_pulse", {31'b0, done1}, 0);

        // T2: wrap-around then a back-to-back op started in the done cycle
        op(1, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, "t2a");
        op(1, 8'hA5, 8'h5A, 1'b1, 8, 8'h00, 1'b1, "t2b");
        tick();

        // T3: start re-pulsed while busy is ignored; old result held during the op
        a = 8'h12; b = 8'h34; cin = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t3_sum_held", {24'b0, sum1}, 32'h00);
        chk("t3_cout_held", {31'b0, cout1}, 1);
        lat = 3;
        while (!done1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("t3_latency", lat, 8);
        chk("t3_sum", {24'b0, sum1}, 32'h46);
        chk("t3_cout", {31'b0, cout1}, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done1) extra++;
        end
        chk("t3_no_second_done", extra, 0);

        // T4: asynchronous reset mid-operation aborts without a done
        a = 8'h55; b = 8'h11; cin = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", {31'b0, busy1}, 0);
        chk("t4_rst_sum", {24'b0, sum1}, 0);
        chk("t4_rst_cout", {31'b0, cout1}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done1 || busy1) extra++;
        end
        chk("t4_no_done_after_abort", extra, 0);
        op(1, 8'h03, 8'h04, 1'b0, 8, 8'h07, 1'b0, "t4_fresh");
        tick();

        // T5: wider digits shorten latency with the same result
        op(4, 8'h9C, 8'h87, 1'b1, 2, 8'h24, 1'b1, "t5_d4");
`ifdef SERADD_OVF_EN
        chk("t5_d4_ovf", {31'b0, ovf4}, 1);
`endif
        tick();
        op(8, 8'h9C, 8'h87, 1'b1, 1, 8'h24, 1'b1, "t5_d8");
        tick();

`ifdef SERADD_OVF_EN
        // T6: signed overflow flag
        op(1, 8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, "t6a");
        chk("t6a_ovf", {31'b0, ovf1}, 1);
        tick();
        op(1, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, "t6b");
        chk("t6b_ovf", {31'b0, ovf1}, 0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
